// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
// Holds state encodings, the nibble width and the WIDTH legality check.
package nibble_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NIBBLE_W = 4;

    // A legal width is a non-zero multiple of the nibble width.
    function automatic bit width_ok(input int w);
        return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_cla.sv
// 4-bit carry-lookahead slice: s = a + b + c0, carries c3 (into bit 3) and c4.
// Ports: a[3:0], b[3:0], c0 in; s[3:0], c4, c3 out. Purely combinational.
module nibble_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4,
    output logic       c3
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    assign p = a ^ b;
    assign g = a & b;

    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single CLA slice.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, out_valid/out_ready, sum,
// cout, busy; ovf (two's-complement overflow) when SERIAL_ADD_OVF_EN is defined.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    if (!width_ok(WIDTH)) begin : g_width_err
        $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 4");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [3:0] sl_a;
    logic [3:0] sl_b;
    logic [3:0] sl_s;
    logic       sl_c4;
    logic       sl_c3;
    logic       last;

    assign sl_a = a_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
    assign sl_b = b_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
    assign last = (idx == IDX_W'(NIB - 1));

    nibble_cla u_cla (
        .a  (sl_a),
        .b  (sl_b),
        .c0 (carry),
        .s  (sl_s),
        .c4 (sl_c4),
        .c3 (sl_c3)
    );

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

`ifndef SERIAL_ADD_OVF_EN
    logic c3_unused;
    assign c3_unused = sl_c3;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        sum   <= '0;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[int'(idx)*NIBBLE_W +: NIBBLE_W] <= sl_s;
                    carry <= sl_c4;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout      <= sl_c4;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
`ifdef SERIAL_ADD_OVF_EN
                        // Carry into the MSB vs carry out of it.
                        ovf       <= sl_c3 ^ sl_c4;
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
// Arithmetic reference model plus directed literal checks and random traffic.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_cmp;
    int n_bad;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 computing, 2 result held.
    int          m_phase;
    int          m_left;
    logic [W:0]  m_pend;
    logic [W:0]  m_res;
    logic        m_ovf_pend;
    logic        m_ovf;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x,
                                     input logic [W-1:0] y,
                                     input logic c);
        logic [W-1:0] low;
        logic [W:0]   full;
        low  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, c};
        full = ref_add(x, y, c);
        return low[W-1] ^ full[W];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_pend  <= '0;
            m_res   <= '0;
            m_ovf_pend <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            if (m_phase == 0) begin
                if (in_valid) begin
                    m_pend     <= ref_add(a, b, cin);
                    m_ovf_pend <= ref_ovf(a, b, cin);
                    m_left     <= NIB;
                    m_phase    <= 1;
                end
            end else if (m_phase == 1) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_res   <= m_pend;
                    m_ovf   <= m_ovf_pend;
                    m_phase <= 2;
                end
            end else if (out_ready) begin
                m_phase <= 0;
            end
        end
    end

    // Compare on every falling edge once reset has been applied.
    bit cmp_en;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            if (m_phase != 1) begin
                chk("sum", 32'(sum), 32'(m_res[W-1:0]));
                chk("cout", 32'(cout), 32'(m_res[W]));
            end
`ifdef SERIAL_ADD_OVF_EN
            if (m_phase == 2) chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    task automatic op(input string nm, input logic [W-1:0] ta,
                      input logic [W-1:0] tb, input logic tc,
                      input logic [W:0] exp, input logic exp_ovf);
        logic acc;
        int   lat;
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) begin
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b1;
        chk({nm, "_accept"}, 32'(acc), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, NIB);
        chk({nm, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        chk({nm, "_cout"}, 32'(cout), 32'(exp[W]));
`ifdef SERIAL_ADD_OVF_EN
        chk({nm, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unexpected x");
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] s_hold;
        logic         c_hold;
        int           t_acc [2];
        int           n_acc;
        n_cmp = 0; n_bad = 0; cmp_en = 0;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cmp_en = 1;
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        op("basic", 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
        op("ripple", 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
        op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 17'h10000, 1'b0);
        op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);

        // Back-pressure: hold result for 10 cycles with in_valid pulses.
        a = 16'hA5A5; b = 16'h0F0F; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        s_hold = sum; c_hold = cout;
        chk("bp_sum_lit", 32'(sum), 32'h0000B4B5);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_sum_stable", 32'(sum), 32'(s_hold));
        chk("bp_cout_stable", 32'(cout), 32'(c_hold));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", 32'(in_ready), 32'd1);

        // Reset in the middle of an operation.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op("after_rst", 16'h00FF, 16'h0F01, 1'b0, 17'h01000, 1'b0);

        // Back-to-back: second pair held valid through the first op.
        n_acc = 0;
        out_ready = 1'b1;
        a = 16'h0102; b = 16'h0304; cin = 1'b0; in_valid = 1'b1;
        for (int cyc = 0; cyc < 30 && n_acc < 2; cyc++) begin
            if (in_valid && in_ready) begin
                t_acc[n_acc] = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc == 1) begin
                a = 16'h8000; b = 16'h8000; cin = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", n_acc, 2);
        chk("b2b_interval", t_acc[1] - t_acc[0], NIB + 2);
        for (int i = 0; i < NIB + 2; i++) begin
            @(posedge clk); #1;
        end
        chk("b2b_second", 32'(sum), 32'h00000001);
        chk("b2b_second_c", 32'(cout), 32'd1);
        out_ready = 1'b0;

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = $urandom;
            b   = $urandom;
            cin = $urandom_range(0, 1);
            if ((i % 8) == 0) begin
                a = 16'hFFFF;
                b = W'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
